// File: rtl/mmcm_ctrl.sv
// mmcm_ctrl -- reset and input-select sequencer for the clk_wiz_0_clk_wiz MMCM.
//
// Runs on a free-running reference clock that is not produced by the MMCM.
// Holds the MMCM in reset for a fixed pulse, switches clk_in_sel only inside
// that pulse, qualifies `locked`, retries timed-out locks and reports status.
//
// Ports:
//   clk         in   reference clock (not from the MMCM)
//   resetn      in   asynchronous active-low reset
//   sel_req     in   requested input select, taken when switch_req is accepted
//   switch_req  in   one-cycle request to re-lock on sel_req (RUN / FAULT only)
//   locked_in   in   MMCM locked, asynchronous to clk
//   mmcm_reset  out  MMCM reset, active-high
//   clk_in_sel  out  MMCM input select
//   ready       out  lock acquired and filtered
//   busy        out  reset pulse or lock acquisition in progress
//   error       out  retries exhausted, MMCM parked in reset
//   lost_lock   out  sticky: lock dropped while running
//   retry_cnt   out  lock timeouts since the last fresh start
//
// Parameters: RST_HOLD_CYCLES must be >= 4; MAX_RETRIES in 0..15.
module mmcm_ctrl #(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 4096,
    parameter int LOCK_FILTER     = 8,
    parameter int MAX_RETRIES     = 3,
    parameter bit SEL_DEFAULT     = 1'b0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sel_req,
    input  logic       switch_req,
    input  logic       locked_in,
    output logic       mmcm_reset,
    output logic       clk_in_sel,
    output logic       ready,
    output logic       busy,
    output logic       error,
    output logic       lost_lock,
    output logic [3:0] retry_cnt
);
    localparam int HW = $clog2(RST_HOLD_CYCLES) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
    localparam int FW = $clog2(LOCK_FILTER) + 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [FW-1:0] FLT_LAST  = FW'(LOCK_FILTER - 1);
    localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_FILTER,
        S_RUN,
        S_FAULT
    } state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] to_cnt;
    logic [FW-1:0] flt_cnt;
    logic          sel_pending;
    logic          locked_m;
    logic          locked_s;
    logic [TW-1:0] to_next;
    logic [3:0]    retry_next;

    // locked_in is asynchronous to clk: two flops before anything looks at it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= locked_in;
            locked_s <= locked_m;
        end
    end

    // The timeout counter sticks at its terminal value so a locked_s that
    // chatters between WAIT_LOCK and FILTER can never wrap it.
    assign to_next    = (to_cnt >= TO_LAST) ? to_cnt : to_cnt + TW'(1);
    assign retry_next = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_HOLD;
            hold_cnt    <= '0;
            to_cnt      <= '0;
            flt_cnt     <= '0;
            sel_pending <= SEL_DEFAULT;
            clk_in_sel  <= SEL_DEFAULT;
            mmcm_reset  <= 1'b1;
            ready       <= 1'b0;
            busy        <= 1'b1;
            error       <= 1'b0;
            lost_lock   <= 1'b0;
            retry_cnt   <= 4'd0;
        end else begin
            unique case (state)
                S_HOLD: begin
                    // Select changes one cycle into the pulse, so the MMCM sees
                    // the new input for the rest of the hold before release.
                    if (hold_cnt == '0)
                        clk_in_sel <= sel_pending;
                    if (hold_cnt == HOLD_LAST) begin
                        state      <= S_WAIT_LOCK;
                        mmcm_reset <= 1'b0;
                        to_cnt     <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end

                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state   <= S_FILTER;
                        flt_cnt <= FW'(1);
                        to_cnt  <= to_next;
                    end else if (to_cnt >= TO_LAST) begin
                        if (retry_cnt < RETRY_LIM) begin
                            retry_cnt  <= retry_next;
                            state      <= S_HOLD;
                            hold_cnt   <= '0;
                            mmcm_reset <= 1'b1;
                        end else begin
                            state      <= S_FAULT;
                            mmcm_reset <= 1'b1;
                            busy       <= 1'b0;
                            error      <= 1'b1;
                        end
                    end else begin
                        to_cnt <= to_next;
                    end
                end

                S_FILTER: begin
                    // to_cnt is not cleared on the way back to WAIT_LOCK: the
                    // timeout covers the whole acquisition window.
                    to_cnt <= to_next;
                    if (locked_s) begin
                        flt_cnt <= flt_cnt + FW'(1);
                        if (flt_cnt >= FLT_LAST) begin
                            state <= S_RUN;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        state <= S_WAIT_LOCK;
                    end
                end

                S_RUN: begin
                    // Lock loss wins over a same-cycle switch request; the
                    // request is dropped and the old input is re-locked.
                    if (!locked_s) begin
                        lost_lock  <= 1'b1;
                        retry_cnt  <= 4'd0;
                        state      <= S_HOLD;
                        hold_cnt   <= '0;
                        mmcm_reset <= 1'b1;
                        ready      <= 1'b0;
                        busy       <= 1'b1;
                    end else if (switch_req) begin
                        sel_pending <= sel_req;
                        lost_lock   <= 1'b0;
                        retry_cnt   <= 4'd0;
                        state       <= S_HOLD;
                        hold_cnt    <= '0;
                        mmcm_reset  <= 1'b1;
                        ready       <= 1'b0;
                        busy        <= 1'b1;
                    end
                end

                S_FAULT: begin
                    if (switch_req) begin
                        sel_pending <= sel_req;
                        lost_lock   <= 1'b0;
                        retry_cnt   <= 4'd0;
                        state       <= S_HOLD;
                        hold_cnt    <= '0;
                        busy        <= 1'b1;
                        error       <= 1'b0;
                    end
                end

                default: begin
                    state      <= S_HOLD;
                    hold_cnt   <= '0;
                    mmcm_reset <= 1'b1;
                    ready      <= 1'b0;
                    busy       <= 1'b1;
                    error      <= 1'b0;
                end
            endcase
        end
    end
endmodule
